// File: rtl/keypad_loader_pkg.sv
// Shared encodings for the keypad loader: debounce FSM states, row drive
// patterns, the NONE key code and small column-decode helpers.
package keypad_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW_0 = 4'b1110;
  localparam logic [3:0] ROW_1 = 4'b1101;
  localparam logic [3:0] ROW_2 = 4'b1011;
  localparam logic [3:0] ROW_3 = 4'b0111;

  // Frame result: bit 4 set means no single key; otherwise bits 3:0 are 4*r+c.
  localparam logic [4:0] KEY_NONE = 5'b1_0000;

  function automatic logic [3:0] row_next(input logic [3:0] row_v);
    return {row_v[2:0], row_v[3]};
  endfunction

  // Number of low (pressed) bits, saturated at 2.
  function automatic logic [1:0] low_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) n = n + 3'd1;
      else       n = n;
    end
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_loader_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous push-button.
module btn_sync (
  input  logic CLK,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic rise_r;

  // Synchronizer chain and registered one-cycle rise pulse.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/keypad_loader.sv
// Scans a 4x4 keypad, debounces single-key presses into a hex entry word and
// writes that word to RAM when the commit button is pressed.
module keypad_loader
  import keypad_loader_pkg::*;
#(
  parameter int SCAN_DIV   = 32768,
  parameter int DEB_FRAMES = 4
) (
  input  logic        CLK,
  input  logic        reset,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        commit,
  input  logic [5:0]  addr_sel,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] entry,
  output logic        key_strobe
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_FRAMES);

  logic [DIV_W-1:0] div_r;
  logic [3:0]       row_r;
  logic [1:0]       row_idx_r;
  logic [1:0]       acc_hits_r;
  logic [3:0]       acc_code_r;
  kp_state_e        state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [3:0]       cand_r, cand_n;
  logic [15:0]      entry_r;
  logic             key_strobe_r;
  logic             wr_en_r;
  logic [7:0]       wr_addr_r;
  logic [15:0]      wr_data_r;

  logic             sample_s;
  logic             frame_end_s;
  logic [1:0]       row_hits_s;
  logic [3:0]       row_code_s;
  logic [2:0]       hits_raw_s;
  logic [1:0]       hits_sum_s;
  logic [4:0]       frame_code_s;
  logic             accept_s;
  logic             commit_rise_s;

  btn_sync u_commit_sync (
    .CLK   (CLK),
    .reset (reset),
    .in    (commit),
    .rise  (commit_rise_s)
  );

  // Per-row column decode folded into the running frame result.
  always_comb begin
    sample_s    = (div_r == DIV_MAX);
    frame_end_s = sample_s && (row_idx_r == 2'd3);
    row_hits_s  = low_count(col);
    row_code_s  = {row_idx_r, low_index(col)};
    hits_raw_s  = {1'b0, acc_hits_r} + {1'b0, row_hits_s};
    if (hits_raw_s >= 3'd2) hits_sum_s = 2'd2;
    else                    hits_sum_s = hits_raw_s[1:0];
    if (hits_sum_s != 2'd1)       frame_code_s = KEY_NONE;
    else if (row_hits_s == 2'd1)  frame_code_s = {1'b0, row_code_s};
    else                          frame_code_s = {1'b0, acc_code_r};
  end

  // Divider, row rotation and frame accumulation.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      div_r      <= {DIV_W{1'b0}};
      row_r      <= ROW_0;
      row_idx_r  <= 2'd0;
      acc_hits_r <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (sample_s) begin
      div_r     <= {DIV_W{1'b0}};
      row_r     <= row_next(row_r);
      row_idx_r <= row_idx_r + 2'd1;
      if (frame_end_s) begin
        acc_hits_r <= 2'd0;
        acc_code_r <= 4'd0;
      end else begin
        acc_hits_r <= hits_sum_s;
        if (row_hits_s == 2'd1) acc_code_r <= row_code_s;
      end
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Debounce FSM next state; only moves on a frame end.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    cand_n   = cand_r;
    accept_s = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (frame_code_s != KEY_NONE) begin
            state_n = ST_PRESS_DB;
            cand_n  = frame_code_s[3:0];
            cnt_n   = CNT_ONE;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (frame_code_s == KEY_NONE) begin
            state_n = ST_IDLE;
            cnt_n   = {CNT_W{1'b0}};
          end else if (frame_code_s[3:0] == cand_r) begin
            if ((cnt_r + CNT_ONE) == DEB_MAX) begin
              state_n  = ST_HELD;
              cnt_n    = {CNT_W{1'b0}};
              accept_s = 1'b1;
            end else begin
              cnt_n = cnt_r + CNT_ONE;
            end
          end else begin
            cand_n = frame_code_s[3:0];
            cnt_n  = CNT_ONE;
          end
        end
        ST_HELD: begin
          if (frame_code_s == KEY_NONE) begin
            state_n = ST_REL_DB;
            cnt_n   = CNT_ONE;
          end else begin
            state_n = ST_HELD;
          end
        end
        ST_REL_DB: begin
          if (frame_code_s != KEY_NONE) begin
            state_n = ST_HELD;
            cnt_n   = {CNT_W{1'b0}};
          end else if ((cnt_r + CNT_ONE) == DEB_MAX) begin
            state_n = ST_IDLE;
            cnt_n   = {CNT_W{1'b0}};
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = {CNT_W{1'b0}};
          cand_n  = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      cand_r  <= 4'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      cand_r  <= cand_n;
    end
  end

  // Entry shift register and RAM write port; a simultaneous commit writes the pre-shift word.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      entry_r      <= 16'h0000;
      key_strobe_r <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= 8'h00;
      wr_data_r    <= 16'h0000;
    end else begin
      key_strobe_r <= accept_s;
      wr_en_r      <= commit_rise_s;
      if (commit_rise_s) begin
        wr_addr_r <= {2'b00, addr_sel};
        wr_data_r <= entry_r;
      end
      case ({commit_rise_s, accept_s})
        2'b11:   entry_r <= {12'h000, cand_r};
        2'b10:   entry_r <= 16'h0000;
        2'b01:   entry_r <= {entry_r[11:0], cand_r};
        default: entry_r <= entry_r;
      endcase
    end
  end

  assign row        = row_r;
  assign entry      = entry_r;
  assign key_strobe = key_strobe_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_keypad_loader.sv
// Scoreboard bench for keypad_loader: a keypad model drives col from row, stimulus
// queues expected strobes and writes, and a negedge monitor checks them.
module tb_keypad_loader;
  import keypad_loader_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        commit;
  logic [5:0]  addr_sel;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] entry;
  logic        key_strobe;
  logic [15:0] keys;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] after;
  } wr_exp_t;

  logic [15:0] exp_strobe[$];
  wr_exp_t     exp_wr[$];
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  logic        after_pend = 1'b0;
  logic [15:0] after_val = 16'h0000;

  keypad_loader #(.SCAN_DIV(4), .DEB_FRAMES(3)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .commit     (commit),
    .addr_sel   (addr_sel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .entry      (entry),
    .key_strobe (key_strobe)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: pops expected strobes and writes as the DUT presents them.
  always @(negedge CLK) begin
    if (reset) begin
      if (after_pend) begin
        check16("entry_after_write", entry, after_val);
        after_pend = 1'b0;
      end
      if (key_strobe) begin
        strobe_cnt++;
        if (exp_strobe.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe: got entry 0x%04h expected no strobe", entry);
        end else begin
          check16("strobe_entry", entry, exp_strobe.pop_front());
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wr_en: got addr 0x%02h data 0x%04h expected no write", wr_addr, wr_data);
        end else begin
          wr_exp_t w;
          w = exp_wr.pop_front();
          check16("wr_addr", {8'h00, wr_addr}, {8'h00, w.addr});
          check16("wr_data", wr_data, w.data);
          after_pend = 1'b1;
          after_val  = w.after;
        end
      end
    end
  end

  // Waits (bounded) for row to change into pat; returns #1 after that edge.
  task automatic wait_row(input logic [3:0] pat);
    logic [3:0] prev;
    bit         seen;
    prev = row;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK); #1;
      if (row == pat && prev != pat) seen = 1'b1;
      prev = row;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL row_timeout: got row %b expected transition to %b", row, pat);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) wait_row(ROW_0);
  endtask

  task automatic press_key(input int code, input int hold, input int rel, input logic [15:0] exp_entry);
    wait_row(ROW_0);
    exp_strobe.push_back(exp_entry);
    keys = 16'h0001 << code;
    wait_frames(hold);
    keys = 16'h0000;
    wait_frames(rel);
  endtask

  initial begin
    int s0;
    reset = 1'b0; commit = 1'b0; addr_sel = 6'h00; keys = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check16("rst_row", {12'h000, row}, {12'h000, ROW_0});
    check16("rst_entry", entry, 16'h0000);
    check16("rst_wr_en", {15'h0000, wr_en}, 16'h0000);
    check16("rst_key_strobe", {15'h0000, key_strobe}, 16'h0000);
    @(posedge CLK); #2 reset = 1'b1;

    // Hold r1c2 for five frames: one strobe, entry 0x0006, row keeps scanning.
    s0 = strobe_cnt;
    press_key(6, 5, 4, 16'h0006);
    check16("s1_strobes", 16'(strobe_cnt - s0), 16'd1);
    check16("s1_entry", entry, 16'h0006);
    check16("s1_row_onehot", 16'($countones(~row)), 16'd1);

    // Digits 1, A, 3, F then commit to 0x15.
    press_key(1,  3, 4, 16'h0061);
    press_key(10, 3, 4, 16'h061A);
    press_key(3,  3, 4, 16'h61A3);
    press_key(15, 3, 4, 16'h1A3F);
    addr_sel = 6'h15;
    exp_wr.push_back('{addr: 8'h15, data: 16'h1A3F, after: 16'h0000});
    commit = 1'b1;
    repeat (20) @(posedge CLK);
    #1 commit = 1'b0;
    repeat (6) @(posedge CLK);
    #1 check16("s2_entry_cleared", entry, 16'h0000);

    // Key 5 bouncing on alternate frames.
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      wait_row(ROW_0);
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
    end
    wait_row(ROW_0);
    keys = 16'h0000;
    wait_frames(2);
    check16("s3_strobes", 16'(strobe_cnt - s0), 16'd0);
    check16("s3_entry", entry, 16'h0000);
    check16("s3_wr_addr_hold", {8'h00, wr_addr}, 16'h0015);
    check16("s3_wr_data_hold", wr_data, 16'h1A3F);

    // Two keys r0c0 and r2c3 together.
    s0 = strobe_cnt;
    wait_row(ROW_0);
    keys = 16'h0801;
    wait_frames(6);
    keys = 16'h0000;
    wait_frames(2);
    check16("s4_strobes", 16'(strobe_cnt - s0), 16'd0);

    // Commit edge aligned with accept of key 7 while entry is 0x0012.
    press_key(1, 3, 4, 16'h0001);
    press_key(2, 3, 4, 16'h0012);
    s0 = strobe_cnt;
    addr_sel = 6'h2A;
    wait_row(ROW_0);
    exp_strobe.push_back(16'h0007);
    exp_wr.push_back('{addr: 8'h2A, data: 16'h0012, after: 16'h0007});
    keys = 16'h0080;
    wait_row(ROW_3);
    wait_row(ROW_3);
    wait_row(ROW_3);
    commit = 1'b1;
    wait_frames(1);
    commit = 1'b0;
    keys = 16'h0000;
    wait_frames(4);
    check16("s5_strobes", 16'(strobe_cnt - s0), 16'd1);
    check16("s5_entry", entry, 16'h0007);

    // Reset during PRESS_DB of key 9.
    s0 = strobe_cnt;
    wait_row(ROW_0);
    keys = 16'h0200;
    wait_frames(1);
    repeat (5) @(posedge CLK);
    #3 reset = 1'b0;
    #1;
    check16("s6_row", {12'h000, row}, {12'h000, ROW_0});
    check16("s6_entry", entry, 16'h0000);
    check16("s6_wr_en", {15'h0000, wr_en}, 16'h0000);
    check16("s6_wr_addr", {8'h00, wr_addr}, 16'h0000);
    check16("s6_wr_data", wr_data, 16'h0000);
    check16("s6_key_strobe", {15'h0000, key_strobe}, 16'h0000);
    keys = 16'h0000;
    repeat (3) @(posedge CLK);
    #2 reset = 1'b1;
    wait_frames(5);
    check16("s6_strobes", 16'(strobe_cnt - s0), 16'd0);
    check16("s6_entry_after", entry, 16'h0000);

    check16("strobe_queue_empty", 16'(exp_strobe.size()), 16'd0);
    check16("write_queue_empty", 16'(exp_wr.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
KEYPAD_LOADER -- requirements
Module: keypad_loader

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 32768: clocks per row-drive period.
REQ-002 SHALL have parameter DEB_FRAMES, default 4: consecutive identical scan frames needed to accept a press or a release.
REQ-003 SHALL have port CLK  input  1: single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port row  output  4: active-low keypad row drive; exactly one bit is low at any time.
REQ-006 SHALL have port col  input  4: active-low keypad column sense, pulled up externally.
REQ-007 SHALL have port commit  input  1: asynchronous push-button that requests a RAM write.
REQ-008 SHALL have port addr_sel  input  6: switch-selected target RAM address.
REQ-009 SHALL have port wr_en  output  1: one-cycle RAM write strobe.
REQ-010 SHALL have port wr_addr  output  8: RAM write address.
REQ-011 SHALL have port wr_data  output  16: RAM write data.
REQ-012 SHALL have port entry  output  16: hex word being assembled, for display.
REQ-013 SHALL have port key_strobe  output  1: one-cycle pulse, asserted when a digit is accepted.

Function
REQ-014 SHALL keep a divider counter 0..SCAN_DIV-1 and sample col when the counter equals SCAN_DIV-1.
- On the next edge after that sample, row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 SHALL define a frame as the four samples for rows 0..3.
- The frame result is a single key with code 4*r+c (r = low row index, c = low col bit index), or NONE.
- Zero pressed keys, or two or more pressed keys, both yield NONE.
REQ-016 SHALL run a state machine with states IDLE, PRESS_DB, HELD and REL_DB, evaluated once per frame end.
REQ-017 In IDLE, a single-key frame SHALL go to PRESS_DB with cand=code and cnt=1; a NONE frame stays in IDLE.
REQ-018 In PRESS_DB:
- A frame equal to cand increments cnt; when cnt reaches DEB_FRAMES, the key is accepted and the state goes to HELD.
- A different single-key frame restarts with cand=code and cnt=1.
- A NONE frame returns to IDLE.
REQ-019 On accept, the next edge SHALL set entry <= {entry[11:0], cand} and pulse key_strobe for exactly one cycle.
REQ-020 In HELD, a NONE frame SHALL go to REL_DB with cnt=1; any other frame stays in HELD.
REQ-021 In REL_DB:
- A NONE frame increments cnt; at DEB_FRAMES the state goes to IDLE.
- Any key frame returns to HELD.
- No digit is accepted during HELD or REL_DB (no auto-repeat).
REQ-022 commit SHALL pass through a 2-flop synchronizer and a rising-edge detector.
- The rising edge produces exactly one cycle of wr_en, with wr_addr={2'b00,addr_sel} and wr_data=entry.
- entry is cleared to 0 on the same edge.
REQ-023 If a commit edge and a digit accept occur on the same edge:
- wr_data SHALL carry the pre-shift entry.
- entry SHALL become {12'h000, cand}.
REQ-024 SHALL hold commit steady, with no further wr_en, until commit is released and pressed again.
REQ-025 wr_addr and wr_data SHALL hold their last values while wr_en is low.

Reset
REQ-026 While reset=0, all of the following SHALL hold immediately and asynchronously:
- row=1110, entry=0, wr_en=0, wr_addr=0, wr_data=0, key_strobe=0.
- State=IDLE; divider, cnt and cand = 0; synchronizer and edge flops = 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; after release, scanning restarts at row 0.

Structure
REQ-028 State encodings, row-pattern constants and the NONE code SHALL live in a shared package/header used by keypad_loader and its bench.
REQ-029 The commit synchronizer and edge detector SHALL be one sub-module, btn_sync, with ports CLK, reset, in and rise.
- The scan and debounce logic SHALL remain in keypad_loader.

Verification
REQ-030 The bench SHALL run with SCAN_DIV=4 and DEB_FRAMES=3, and SHALL cover at least these scenarios:
- Hold key r1c2 for 5 frames, then release: exactly one key_strobe, entry=0x0006, and row keeps cycling.
- Enter keys 1, A, 3, F, then pulse commit with addr_sel=0x15: one wr_en with wr_addr=0x15 and wr_data=0x1A3F; entry=0 on the next cycle.
- Bounce key 5 present/absent on alternate frames for 10 frames: no key_strobe and entry unchanged.
- Press r0c0 and r2c3 together for 6 frames: no key_strobe.
- Align a commit edge with the accept of key 7 while entry=0x0012: wr_data=0x0012 and entry=0x0007.
- Assert reset during PRESS_DB of key 9: all outputs return to reset values, with no strobe after release.
